// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/decode stage: widths, ALU op
// codes, RV32I opcodes and the decoded issue bundle.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 4;

  typedef enum logic [OPW-1:0] {
    ALU_ADD = 4'b0000,
    ALU_SLL = 4'b0001,
    ALU_SLT = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_OR  = 4'b0110,
    ALU_AND = 4'b0111,
    ALU_SUB = 4'b1000,
    ALU_SRA = 4'b1101
  } alu_op_t;

  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    alu_op_t         operation;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;
  } issue_bundle_t;

  // funct3 plus the alternate bit (instr[30]) to ALU op; SLT is remapped to
  // 0011 because 0010 is reserved in the ALU. 011 never reaches the ALU.
  function automatic alu_op_t f3_to_op(input logic alt, input logic [2:0] funct3);
    case (funct3)
      3'b000:  f3_to_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_to_op = ALU_SLL;
      3'b010:  f3_to_op = ALU_SLT;
      3'b100:  f3_to_op = ALU_XOR;
      3'b101:  f3_to_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_to_op = ALU_OR;
      3'b111:  f3_to_op = ALU_AND;
      default: f3_to_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_decoder_if.sv
// Upstream instruction handshake and downstream ALU issue handshake of the
// decode stage. Valid/ready: a beat moves on a rising edge where both are 1;
// valid and its payload must not change while valid=1 and ready=0.
interface alu_issue_decoder_if import alu_pkg::*;;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_operand_a;
  logic [XLEN-1:0] alu_operand_b;
  logic [OPW-1:0]  alu_operation;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, alu_operand_a, alu_operand_b, alu_operation,
           out_rd, out_reg_write, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, alu_operand_a, alu_operand_b, alu_operation,
           out_rd, out_reg_write, out_illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I ALU-class decoder: instruction, PC and register data in,
// issue bundle out. Anything not decodable issues as an illegal ADD of zeros.
module alu_op_decode import alu_pkg::*; (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output issue_bundle_t   bundle_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            legal;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  alu_op_t         op;
  logic            unused_rs_fields;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign unused_rs_fields = ^instr_i[19:15];

  always_comb begin
    legal = 1'b0;
    op_a  = '0;
    op_b  = '0;
    op    = ALU_ADD;
    case (opcode)
      OP_REG: begin
        op_a  = rs1_data_i;
        op_b  = rs2_data_i;
        op    = f3_to_op(instr_i[30], funct3);
        legal = (funct7 == 7'b0000000 && funct3 != 3'b011) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OP_IMM: begin
        op_a = rs1_data_i;
        op_b = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
        op   = f3_to_op((funct3 == 3'b101) && instr_i[30], funct3);
        case (funct3)
          3'b001: begin
            legal = (funct7 == 7'b0000000);
            op_b  = {{(XLEN-5){1'b0}}, instr_i[24:20]};
          end
          3'b101: begin
            legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            op_b  = {{(XLEN-5){1'b0}}, instr_i[24:20]};
          end
          3'b011:  legal = 1'b0;
          default: legal = 1'b1;
        endcase
      end
      OP_LUI: begin
        op_b  = {instr_i[31:12], 12'b0};
        legal = 1'b1;
      end
      OP_AUIPC: begin
        op_a  = pc_i;
        op_b  = {instr_i[31:12], 12'b0};
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    bundle_o           = '0;
    bundle_o.rd        = instr_i[11:7];
    bundle_o.illegal   = !legal;
    bundle_o.operation = ALU_ADD;
    if (legal) begin
      bundle_o.operand_a = op_a;
      bundle_o.operand_b = op_b;
      bundle_o.operation = op;
      bundle_o.reg_write = (instr_i[11:7] != 5'd0);
    end
  end

endmodule

// File: rtl/alu_issue_decoder.sv
// Decode/issue stage: decodes one instruction per cycle and holds the result in
// a main + skid register pair so in_ready can be registered at full throughput.
module alu_issue_decoder import alu_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  alu_issue_decoder_if.slave  bus
);

  issue_bundle_t dec;
  issue_bundle_t main_q, main_d;
  issue_bundle_t skid_q, skid_d;
  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          in_ready_q;
  logic          accept;
  logic          drain;

  alu_op_decode u_decode (
    .instr_i    (bus.in_instr),
    .pc_i       (bus.in_pc),
    .rs1_data_i (bus.in_rs1_data),
    .rs2_data_i (bus.in_rs2_data),
    .bundle_o   (dec)
  );

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = main_valid_q && bus.out_ready;

  // in_ready_q is low whenever skid is full, so a skid-full cycle never accepts.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (drain) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || drain) begin
      main_valid_d = accept;
      if (accept) main_d = dec;
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = main_valid_q;
  assign bus.alu_operand_a = main_q.operand_a;
  assign bus.alu_operand_b = main_q.operand_b;
  assign bus.alu_operation = main_q.operation;
  assign bus.out_rd        = main_q.rd;
  assign bus.out_reg_write = main_q.reg_write;
  assign bus.out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed-vector bench for alu_issue_decoder with a queue-based scoreboard and
// an independent output monitor that also checks stability under backpressure.
module tb_alu_issue_decoder;
  import alu_pkg::*;

  localparam int W = 2*XLEN + OPW + 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_decoder_if bus ();

  alu_issue_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int last_pop_cyc = 0;
  int pop_gap = 0;
  int pops = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act;
  logic         hold = 1'b0;
  logic [W-1:0] held;

  assign act = {bus.alu_operand_a, bus.alu_operand_b, bus.alu_operation,
                bus.out_rd, bus.out_reg_write, bus.out_illegal};

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [W-1:0] bundle(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                          input logic [OPW-1:0] op, input logic [4:0] rd,
                                          input logic rw, input logic ill);
    return {a, b, op, rd, rw, ill};
  endfunction

  // Monitor: pops the scoreboard on each output transfer, checks holds.
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", W'(bus.out_valid), W'(1));
        check("hold_stable", act, held);
      end
      hold = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_bundle: got %h expected none", act);
        end else begin
          check("bundle", act, exp_q.pop_front());
        end
        pop_gap = cyc - last_pop_cyc;
        last_pop_cyc = cyc;
        pops++;
      end else if (bus.out_valid) begin
        hold = 1'b1;
        held = act;
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [XLEN-1:0] pc,
                      input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                      input logic [W-1:0] exp);
    int t = 0;
    bus.in_valid    = 1'b1;
    bus.in_instr    = instr;
    bus.in_pc       = pc;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) begin
      total++;
      $display("FAIL send_timeout: in_ready got 0 required 1");
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: pending got %0d required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.in_rs1_data = '0;
    bus.in_rs2_data = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", W'(bus.out_valid), W'(0));
    check("reset_in_ready", W'(bus.in_ready), W'(0));
    check("reset_outputs", act, '0);
    rst = 1'b0;
    check("release_out_valid", W'(bus.out_valid), W'(0));
    @(posedge clk); #1;
    check("release_in_ready", W'(bus.in_ready), W'(1));

    // add x3,x1,x2
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, bundle(32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0));
    wait_drain();

    // sub then srai back-to-back
    send(32'h402081B3, 32'h0, 32'd9, 32'd4, bundle(32'd9, 32'd4, 4'b1000, 5'd3, 1'b1, 1'b0));
    send(32'h40335293, 32'h0, 32'h80000000, 32'h0,
         bundle(32'h80000000, 32'd3, 4'b1101, 5'd5, 1'b1, 1'b0));
    wait_drain();
    check("no_bubble", W'(pop_gap), W'(1));

    // immediates, upper-immediates, shifts and compares
    send(32'hFFF00093, 32'h0, 32'h0, 32'h0, bundle(32'h0, 32'hFFFFFFFF, 4'b0000, 5'd1, 1'b1, 1'b0));
    send(32'h123452B7, 32'h0, 32'hDEAD, 32'h0, bundle(32'h0, 32'h12345000, 4'b0000, 5'd5, 1'b1, 1'b0));
    send(32'h00001517, 32'h100, 32'h0, 32'h0, bundle(32'h100, 32'h1000, 4'b0000, 5'd10, 1'b1, 1'b0));
    send(32'h00409113, 32'h0, 32'h33, 32'h0, bundle(32'h33, 32'd4, 4'b0001, 5'd2, 1'b1, 1'b0));
    send(32'h0020A233, 32'h0, 32'd1, 32'd2, bundle(32'd1, 32'd2, 4'b0011, 5'd4, 1'b1, 1'b0));
    // illegal: slli with imm[11:5]=0100000, sltu, unknown opcode
    send(32'h40409113, 32'h0, 32'h33, 32'h0, bundle(32'h0, 32'h0, 4'b0000, 5'd2, 1'b0, 1'b1));
    send(32'h0020B1B3, 32'h0, 32'd1, 32'd2, bundle(32'h0, 32'h0, 4'b0000, 5'd3, 1'b0, 1'b1));
    send(32'h0000037F, 32'h44, 32'd1, 32'd2, bundle(32'h0, 32'h0, 4'b0000, 5'd6, 1'b0, 1'b1));
    // addi x0,x0,1: legal but no write-back
    send(32'h00100013, 32'h0, 32'h11, 32'h0, bundle(32'h11, 32'd1, 4'b0000, 5'd0, 1'b0, 1'b0));
    wait_drain();

    // backpressure: xor, or, and while out_ready=0
    base = pops;
    bus.out_ready = 1'b0;
    send(32'h0020C3B3, 32'h0, 32'hF0, 32'h3C, bundle(32'hF0, 32'h3C, 4'b0100, 5'd7, 1'b1, 1'b0));
    send(32'h0020E433, 32'h0, 32'hF1, 32'h3D, bundle(32'hF1, 32'h3D, 4'b0110, 5'd8, 1'b1, 1'b0));
    check("stall_in_ready_full", W'(bus.in_ready), W'(0));
    fork
      send(32'h0020F4B3, 32'h0, 32'hF2, 32'h3E, bundle(32'hF2, 32'h3E, 4'b0111, 5'd9, 1'b1, 1'b0));
      begin
        repeat (3) @(posedge clk);
        #1;
        check("stall_in_ready_held", W'(bus.in_ready), W'(0));
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_count", W'(pops - base), W'(3));

    // reset with main and skid both full
    bus.out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd1, 32'd1, bundle(32'd1, 32'd1, 4'b0000, 5'd3, 1'b1, 1'b0));
    send(32'h002081B3, 32'h0, 32'd2, 32'd2, bundle(32'd2, 32'd2, 4'b0000, 5'd3, 1'b1, 1'b0));
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_out_valid", W'(bus.out_valid), W'(0));
    check("midreset_outputs", act, '0);
    check("midreset_in_ready", W'(bus.in_ready), W'(0));
    exp_q.delete();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    check("midrelease_out_valid", W'(bus.out_valid), W'(0));
    @(posedge clk); #1;
    check("midrelease_in_ready", W'(bus.in_ready), W'(1));
    base = pops;
    send(32'h002081B3, 32'h0, 32'd8, 32'd9, bundle(32'd8, 32'd9, 4'b0000, 5'd3, 1'b1, 1'b0));
    wait_drain();
    check("post_reset_count", W'(pops - base), W'(1));
    check("queue_empty", W'(exp_q.size()), W'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
